// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and width helpers for the UART transmitter
package uart_pkg;

    // 3-bit encoding leaves illegal codes that the FSM folds back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_state_e;

    // bit index covers up to 9 data bits and the stop-bit count
    localparam int IDX_W = 4;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with a one-cycle bit_done pulse
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic UART_CLK,
    input  logic nRST,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done = !restart && (cnt_q == CNT_LAST);

    always_ff @(posedge UART_CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (restart || bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parameterised UART transmitter; parity bit enabled by UART_TX_PARITY_EN
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 UART_CLK,
    input  logic                 nRST,
    input  logic [DATA_BITS-1:0] TX_Data,
    input  logic                 TX_Valid,
    output logic                 TX_Ready,
    output logic                 TX_Busy,
    output logic                 UART_TX
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_param: illegal parameter value");
    end

    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ready_q, tx_q, tx_d;
    logic                 bit_done;
    logic                 transfer;

    assign transfer = TX_Valid && ready_q;
    assign TX_Ready = ready_q;
    assign TX_Busy  = (state_q != ST_IDLE);
    assign UART_TX  = tx_q;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .UART_CLK (UART_CLK),
        .nRST     (nRST),
        .restart  (state_q == ST_IDLE),
        .bit_done (bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge UART_CLK or negedge nRST) begin
        if (!nRST) begin
            par_q <= 1'b0;
        end else if (transfer) begin
            par_q <= (^TX_Data) ^ (PARITY_ODD != 0);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_START;
                    shift_d = TX_Data;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // line is registered, so it is decoded from the state being entered
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge UART_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == ST_IDLE);
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param with a line-level scoreboard
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0, a_ready, a_busy, a_tx;
    logic [4:0] b_data = '0;
    logic       b_valid = 1'b0, b_ready, b_busy, b_tx;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .UART_CLK(clk), .nRST(rst_n), .TX_Data(a_data), .TX_Valid(a_valid),
        .TX_Ready(a_ready), .TX_Busy(a_busy), .UART_TX(a_tx)
    );

    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .UART_CLK(clk), .nRST(rst_n), .TX_Data(b_data), .TX_Valid(b_valid),
        .TX_Ready(b_ready), .TX_Busy(b_busy), .UART_TX(b_tx)
    );

`ifdef UART_TX_PARITY_EN
    logic [7:0] p_data = '0;
    logic       pe_valid = 1'b0, pe_ready, pe_busy, pe_tx;
    logic       po_valid = 1'b0, po_ready, po_busy, po_tx;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_pe (
        .UART_CLK(clk), .nRST(rst_n), .TX_Data(p_data), .TX_Valid(pe_valid),
        .TX_Ready(pe_ready), .TX_Busy(pe_busy), .UART_TX(pe_tx)
    );

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_po (
        .UART_CLK(clk), .nRST(rst_n), .TX_Data(p_data), .TX_Valid(po_valid),
        .TX_Ready(po_ready), .TX_Busy(po_busy), .UART_TX(po_tx)
    );
`endif

    task automatic drive(input int sel, input logic [8:0] d, input logic v);
        case (sel)
            0: begin a_data = d[7:0]; a_valid = v; end
            1: begin b_data = d[4:0]; b_valid = v; end
`ifdef UART_TX_PARITY_EN
            2: begin p_data = d[7:0]; pe_valid = v; end
            3: begin p_data = d[7:0]; po_valid = v; end
`endif
            default: ;
        endcase
    endtask

    task automatic sample(input int sel, output logic tx, output logic rdy, output logic bsy);
        tx = 1'bx; rdy = 1'bx; bsy = 1'bx;
        case (sel)
            0: begin tx = a_tx; rdy = a_ready; bsy = a_busy; end
            1: begin tx = b_tx; rdy = b_ready; bsy = b_busy; end
`ifdef UART_TX_PARITY_EN
            2: begin tx = pe_tx; rdy = pe_ready; bsy = pe_busy; end
            3: begin tx = po_tx; rdy = po_ready; bsy = po_busy; end
`endif
            default: ;
        endcase
    endtask

    task automatic push_frame(input logic [8:0] d, input int nbits, input int cpb,
                              input int stops, input int par_en, input int par_odd);
        logic p;
        p = (par_odd != 0);
        repeat (cpb) exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            p = p ^ d[i];
            repeat (cpb) exp_q.push_back(d[i]);
        end
        if (par_en != 0) repeat (cpb) exp_q.push_back(p);
        repeat (stops * cpb) exp_q.push_back(1'b1);
    endtask

    task automatic wait_ready(input int sel);
        logic tx, rdy, bsy;
        rdy = 1'b0;
        for (int i = 0; i < 100 && rdy !== 1'b1; i++) begin
            @(negedge clk);
            sample(sel, tx, rdy, bsy);
        end
        if (rdy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_ready dut%0d: TX_Ready=%b after 100 cycles, expected 1", sel, rdy);
        end
    endtask

    // drives one word, then checks every line cycle against the scoreboard
    task automatic check_frame(input int sel, input logic [8:0] d, input int nbits, input int cpb,
                               input int stops, input int par_en, input int par_odd,
                               input bit corrupt, input string name);
        logic tx, rdy, bsy, e;
        int total;
        wait_ready(sel);
        drive(sel, d, 1'b1);
        push_frame(d, nbits, cpb, stops, par_en, par_odd);
        total = cpb * (1 + nbits + par_en + stops);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) drive(sel, d, 1'b0);
            if (corrupt && k == 10) drive(sel, 9'h1FF, 1'b0);
            sample(sel, tx, rdy, bsy);
            e = exp_q.pop_front();
            checks++;
            if (tx !== e || rdy !== 1'b0 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL %s cycle %0d: tx=%b ready=%b busy=%b, expected tx=%b ready=0 busy=1",
                         name, k, tx, rdy, bsy, e);
            end
        end
        @(negedge clk);
        sample(sel, tx, rdy, bsy);
        checks++;
        if (tx !== 1'b1 || rdy !== 1'b1 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL %s end cycle %0d: tx=%b ready=%b busy=%b, expected tx=1 ready=1 busy=0",
                     name, total + 1, tx, rdy, bsy);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_tx !== 1'b1 || a_ready !== 1'b0 || a_busy !== 1'b0 ||
            b_tx !== 1'b1 || b_ready !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: a tx/rdy/busy=%b%b%b b=%b%b%b, expected 100 100",
                     a_tx, a_ready, a_busy, b_tx, b_ready, b_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_tx !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: a_ready=%b b_ready=%b a_tx=%b a_busy=%b, expected 1 1 1 0",
                     a_ready, b_ready, a_tx, a_busy);
        end
    endtask

    task automatic test_frame_patterns;
        check_frame(0, 9'h055, 8, 4, 1, 0, 0, 1'b0, "frame_55");
        check_frame(0, 9'h096, 8, 4, 1, 0, 0, 1'b0, "frame_96");
    endtask

    task automatic test_data_hold;
        check_frame(0, 9'h000, 8, 4, 1, 0, 0, 1'b1, "data_hold");
    endtask

    task automatic test_back_to_back;
        logic tx, rdy, bsy, e;
        wait_ready(0);
        drive(0, 9'h0A5, 1'b1);
        push_frame(9'h0A5, 8, 4, 1, 0, 0);
        exp_q.push_back(1'b1);
        push_frame(9'h03C, 8, 4, 1, 0, 0);
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 9'h03C, 1'b1);
            if (k == 42) drive(0, 9'h03C, 1'b0);
            sample(0, tx, rdy, bsy);
            e = exp_q.pop_front();
            checks++;
            if (tx !== e || rdy !== (k == 41) || bsy !== (k != 41)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: tx=%b ready=%b busy=%b, expected tx=%b ready=%b busy=%b",
                         k, tx, rdy, bsy, e, (k == 41), (k != 41));
            end
        end
        @(negedge clk);
        checks++;
        if (a_tx !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back end: tx=%b ready=%b busy=%b, expected 1 1 0", a_tx, a_ready, a_busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        wait_ready(0);
        drive(0, 9'h000, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 9'h000, 1'b0);
            checks++;
            if (a_tx !== 1'b0 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL pre_abort cycle %0d: tx=%b busy=%b, expected 0 1", k, a_tx, a_busy);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: tx=%b busy=%b ready=%b, expected 1 0 0", a_tx, a_busy, a_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: tx=%b busy=%b ready=%b, expected 1 0 1", a_tx, a_busy, a_ready);
        end
        check_frame(0, 9'h0C3, 8, 4, 1, 0, 0, 1'b0, "after_abort");
    endtask

    task automatic test_short_frame;
        check_frame(1, 9'h01F, 5, 2, 2, 0, 0, 1'b0, "short_1f");
        check_frame(1, 9'h00A, 5, 2, 2, 0, 0, 1'b0, "short_0a");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        check_frame(2, 9'h007, 8, 4, 1, 1, 0, 1'b0, "parity_even_07");
        check_frame(3, 9'h007, 8, 4, 1, 1, 1, 1'b0, "parity_odd_07");
        check_frame(2, 9'h0B4, 8, 4, 1, 1, 0, 1'b0, "parity_even_b4");
    endtask
`endif

    initial begin
        test_reset;
        test_frame_patterns;
        test_data_hold;
        test_back_to_back;
        test_reset_mid_frame;
        test_short_frame;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, frame data width (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, UART_CLK cycles per bit (legal 2..65535).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop-bit count (legal 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0; 1 = odd parity, 0 = even parity.
REQ-005 SHALL have port UART_CLK  input  1  sole clock; all logic rises on posedge.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port TX_Data  input  DATA_BITS  word to send.
REQ-008 SHALL have port TX_Valid  input  1  producer offers TX_Data.
REQ-009 SHALL have port TX_Ready  output  1  block can accept a word this cycle.
REQ-010 SHALL have port TX_Busy  output  1  frame in progress (any state except IDLE).
REQ-011 SHALL have port UART_TX  output  1  serial line, idle high, registered.

Function
REQ-012 SHALL implement the FSM IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive TX_Ready high only in IDLE; a transfer occurs on TX_Valid && TX_Ready at a rising edge.
REQ-014 SHALL capture TX_Data into a shift register at the transfer and ignore later TX_Data changes.
REQ-015 SHALL ignore TX_Valid while TX_Ready is low; no word is queued or dropped-with-flag.
REQ-016 SHALL drive UART_TX low (start bit) from the cycle after the transfer; latency is 1 clock.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-period counter cleared at every bit boundary.
REQ-018 SHALL send data LSB first, DATA_BITS bits, counted with a bit index that terminates at DATA_BITS-1 (no off-by-one).
REQ-019 SHALL with parity compiled in send one parity bit after DATA: XOR of captured word, inverted when PARITY_ODD=1.
REQ-020 SHALL send STOP_BITS high bits, then enter IDLE, with TX_Ready rising in the cycle after the last stop-bit cycle.
REQ-021 SHALL allow back-to-back frames: transfer in the first IDLE cycle gives exactly one idle-high clock between frames.
REQ-022 SHALL keep UART_TX high in IDLE and go to IDLE from any illegal state encoding.
REQ-023 SHALL size the bit-period counter as $clog2(CLKS_PER_BIT) bits, with the terminal value CLKS_PER_BIT-1.

Reset
REQ-024 SHALL on nRST low force, without a clock: state IDLE, UART_TX=1, TX_Ready=0 while nRST is low, TX_Busy=0, counters=0.
REQ-025 SHALL abort any frame in progress on reset; the partial frame is not resumed and the captured word is lost.
REQ-026 SHALL assert TX_Ready on the first rising edge after nRST deasserts.

Configuration
REQ-027 SHALL compile the PARITY state and parity logic only when UART_TX_PARITY_EN is defined.
REQ-028 SHALL without UART_TX_PARITY_EN go DATA->STOP directly, ignore PARITY_ODD, and have no parity logic.

Structure
REQ-029 SHALL take the state enum type and the bit-width helper constants from shared package uart_pkg.
REQ-030 SHALL place the bit-period counter and one-cycle bit_done pulse in sub-module uart_bit_timer (parameter CLKS_PER_BIT, input restart).

Verification (DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
REQ-031 SHALL cover: send 0x55, no parity -> UART_TX 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit, TX_Ready high 41 clocks after transfer.
REQ-032 SHALL cover: UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
REQ-033 SHALL cover: TX_Valid held high, words 0xA5 then 0x3C -> two frames separated by exactly one idle-high clock.
REQ-034 SHALL cover: TX_Data changed to 0xFF mid-frame after accepting 0x00 -> all data bits remain 0.
REQ-035 SHALL cover: nRST pulsed low during data bit 3 -> UART_TX high immediately, TX_Busy 0, new frame starts cleanly after release.
REQ-036 SHALL cover: DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=2, send 0x1F -> 8 bit periods (start, 5 data, 2 stop) = 16 clocks.
